uart_rx_fifo: RTL and testbench

//  Receive FIFO between the UART RX deserialiser and the register interface (RBR/LSR/IIR).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo_mem.sv | 22 ++
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FIFO sizing, RX entry layout and FCR trigger decode.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned UART_ERR_W      = 3;

  typedef struct packed {
    logic [2:0] err;
    logic [7:0] data;
  } uart_rx_entry_t;

  // FCR[7:6] receive trigger level in characters.
  function automatic int unsigned uart_trig_thr(input bit [1:0] sel);
    case (sel)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with per-character error flags, trigger/timeout interrupts and LSR status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TOUT_CHARS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [2:0]               wr_err,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [2:0]               rd_err,
  input  logic                     fifo_clr,
  input  logic [1:0]               trig_sel,
  input  logic                     char_tick,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic                     err_in_fifo,
  output logic                     trig_irq,
  output logic                     tout_irq
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned ENT_W = DATA_W + UART_ERR_W;
  localparam logic [2:0]  TOUT_MAX = 3'(TOUT_CHARS);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
  logic [2:0]       tout_q, tout_d;
  logic             ovr_q, ovr_d;
  logic             full, push, pop, push_err, pop_err;
  logic [ENT_W-1:0] rd_entry;

  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // When full, a simultaneous pop frees the slot the push then lands in.
  assign push     = !fifo_clr && wr_en && (!full || rd_en);
  assign pop      = !fifo_clr && rd_en && !empty;
  assign push_err = push && (wr_err != 3'b000);
  assign pop_err  = pop && (rd_err != 3'b000);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    tout_d    = tout_q;
    ovr_d     = ovr_q && !ovr_clr;

    if (!fifo_clr && wr_en && full && !rd_en) ovr_d = 1'b1;

    if (fifo_clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + PTR_W'(1);
        2'b01:   count_d = count_q - PTR_W'(1);
        default: count_d = count_q;
      endcase
      case ({push_err, pop_err})
        2'b10:   err_cnt_d = err_cnt_q + PTR_W'(1);
        2'b01:   err_cnt_d = err_cnt_q - PTR_W'(1);
        default: err_cnt_d = err_cnt_q;
      endcase
    end

    if (fifo_clr || push || pop || empty) tout_d = 3'd0;
    else if (char_tick && (tout_q != TOUT_MAX)) tout_d = tout_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      tout_q    <= 3'd0;
      ovr_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      tout_q    <= tout_d;
      ovr_q     <= ovr_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({wr_err, wr_data}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  assign rd_data     = rd_entry[DATA_W-1:0];
  assign rd_err      = rd_entry[ENT_W-1:DATA_W];
  assign count       = count_q;
  assign overrun     = ovr_q;
  assign err_in_fifo = (err_cnt_q != '0);
  assign trig_irq    = (count_q >= PTR_W'(uart_trig_thr(trig_sel)));
  assign tout_irq    = (tout_q == TOUT_MAX) && !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: push/pop scenarios checked against an expected-entry queue.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en, fifo_clr, char_tick, ovr_clr;
  logic [7:0] wr_data, rd_data;
  logic [2:0] wr_err, rd_err;
  logic [1:0] trig_sel;
  logic [4:0] count;
  logic       empty, overrun, err_in_fifo, trig_irq, tout_irq;

  int checks = 0;
  int errors = 0;
  uart_rx_entry_t sb[$];
  logic mdl_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .fifo_clr(fifo_clr),
    .trig_sel(trig_sel), .char_tick(char_tick), .count(count), .empty(empty),
    .overrun(overrun), .ovr_clr(ovr_clr), .err_in_fifo(err_in_fifo),
    .trig_irq(trig_irq), .tout_irq(tout_irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d, input logic [2:0] e);
    uart_rx_entry_t ent;
    ent.data = d;
    ent.err  = e;
    wr_en = 1'b1; wr_data = d; wr_err = e;
    if (sb.size() < 16) sb.push_back(ent);
    else mdl_ovr = 1'b1;
    step();
    wr_en = 1'b0; wr_err = 3'b000;
  endtask

  task automatic do_pop();
    uart_rx_entry_t ent;
    checks++;
    if (sb.size() == 0) begin
      if (empty !== 1'b1) begin
        errors++; $display("FAIL pop_empty: empty=%b required 1", empty);
      end
    end else begin
      ent = sb.pop_front();
      if (rd_data !== ent.data || rd_err !== ent.err) begin
        errors++;
        $display("FAIL pop_head: got %h/%b required %h/%b", rd_data, rd_err, ent.data, ent.err);
      end
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic check_count(input string tag);
    checks++;
    if (count !== 5'(sb.size()) || empty !== (sb.size() == 0)) begin
      errors++;
      $display("FAIL %s count: got %0d/empty=%b required %0d", tag, count, empty, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; fifo_clr = 1'b0; char_tick = 1'b0;
    ovr_clr = 1'b0; wr_data = 8'h00; wr_err = 3'b000; trig_sel = 2'b00;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || err_in_fifo !== 1'b0 ||
        trig_irq !== 1'b0 || tout_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt=%0d e=%b o=%b ef=%b t=%b to=%b required 0/1/0/0/0/0",
               count, empty, overrun, err_in_fifo, trig_irq, tout_irq);
    end
  endtask

  task automatic test_trigger();
    trig_sel = 2'b11;
    for (int i = 0; i < 13; i++) do_push(8'(i + 8'h40), 3'b000);
    checks++;
    if (trig_irq !== 1'b0) begin errors++; $display("FAIL trig13: got %b required 0", trig_irq); end
    do_push(8'h4D, 3'b000);
    checks++;
    if (trig_irq !== 1'b1) begin errors++; $display("FAIL trig14: got %b required 1", trig_irq); end
    check_count("trig14");
    do_pop();
    checks++;
    if (trig_irq !== 1'b0) begin errors++; $display("FAIL trig_pop: got %b required 0", trig_irq); end
    trig_sel = 2'b10;
    #1;
    checks++;
    if (trig_irq !== 1'b1) begin errors++; $display("FAIL trig_sel8: got %b required 1", trig_irq); end
    while (sb.size() > 0) do_pop();
    check_count("trig_drain");
    trig_sel = 2'b00;
    do_push(8'h01, 3'b000);
    checks++;
    if (trig_irq !== 1'b1) begin errors++; $display("FAIL trig1: got %b required 1", trig_irq); end
    do_pop();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) do_push(8'(i), 3'b000);
    do_push(8'hAA, 3'b000);
    check_count("ovr_full");
    checks++;
    if (overrun !== mdl_ovr) begin errors++; $display("FAIL ovr_set: got %b required %b", overrun, mdl_ovr); end
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0; mdl_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b required 0", overrun); end
    ovr_clr = 1'b1;
    do_push(8'hAB, 3'b000);
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b required 1", overrun); end
    while (sb.size() > 0) do_pop();
    check_count("ovr_drain");
    do_pop();
    check_count("pop_on_empty");
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0; mdl_ovr = 1'b0;
  endtask

  task automatic test_err_flag();
    do_push(8'h11, 3'b000);
    do_push(8'h55, 3'b010);
    do_push(8'h22, 3'b000);
    checks++;
    if (err_in_fifo !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", err_in_fifo); end
    do_pop();
    checks++;
    if (err_in_fifo !== 1'b1) begin errors++; $display("FAIL err_hold: got %b required 1", err_in_fifo); end
    do_pop();
    checks++;
    if (err_in_fifo !== 1'b0) begin errors++; $display("FAIL err_clr: got %b required 0", err_in_fifo); end
    do_pop();
    check_count("err_drain");
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      char_tick = 1'b1; step(); char_tick = 1'b0; step();
    end
  endtask

  task automatic test_timeout();
    do_push(8'hC1, 3'b000);
    do_push(8'hC2, 3'b000);
    tick_n(3);
    checks++;
    if (tout_irq !== 1'b0) begin errors++; $display("FAIL tout3: got %b required 0", tout_irq); end
    tick_n(1);
    checks++;
    if (tout_irq !== 1'b1) begin errors++; $display("FAIL tout4: got %b required 1", tout_irq); end
    tick_n(2);
    checks++;
    if (tout_irq !== 1'b1) begin errors++; $display("FAIL tout_sat: got %b required 1", tout_irq); end
    do_pop();
    checks++;
    if (tout_irq !== 1'b0) begin errors++; $display("FAIL tout_rd: got %b required 0", tout_irq); end
    tick_n(3);
    checks++;
    if (tout_irq !== 1'b0) begin errors++; $display("FAIL tout_idle3: got %b required 0", tout_irq); end
    do_pop();
    tick_n(5);
    checks++;
    if (tout_irq !== 1'b0) begin errors++; $display("FAIL tout_empty: got %b required 0", tout_irq); end
  endtask

  task automatic test_full_simul();
    uart_rx_entry_t ent, head;
    for (int i = 0; i < 16; i++) do_push(8'(8'h30 + i), 3'b000);
    for (int i = 0; i < 3; i++) begin
      ent.data = 8'(8'h80 + i);
      ent.err  = 3'b000;
      head = sb.pop_front();
      checks++;
      if (rd_data !== head.data) begin
        errors++; $display("FAIL simul_head: got %h required %h", rd_data, head.data);
      end
      sb.push_back(ent);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = ent.data; wr_err = ent.err;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
    end
    check_count("simul_full");
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL simul_ovr: got %b required 0", overrun); end
    while (sb.size() > 0) do_pop();
    check_count("simul_drain");
  endtask

  task automatic test_clr_reset();
    trig_sel = 2'b00;
    for (int i = 0; i < 16; i++) do_push(8'(8'hE0 + i), (i == 10) ? 3'b100 : 3'b000);
    do_push(8'hEE, 3'b000);
    for (int i = 0; i < 4; i++) do_pop();
    checks++;
    if (overrun !== 1'b1 || err_in_fifo !== 1'b1) begin
      errors++; $display("FAIL pre_clr: ovr=%b ef=%b required 1/1", overrun, err_in_fifo);
    end
    fifo_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    step();
    fifo_clr = 1'b0; wr_en = 1'b0;
    sb.delete();
    check_count("clr");
    checks++;
    if (trig_irq !== 1'b0 || err_in_fifo !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL clr_flags: t=%b ef=%b ovr=%b required 0/0/1", trig_irq, err_in_fifo, overrun);
    end
    do_push(8'h91, 3'b001);
    do_push(8'h92, 3'b000);
    do_pop();
    wr_en = 1'b1; wr_data = 8'h93; wr_err = 3'b001;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || err_in_fifo !== 1'b0 ||
        trig_irq !== 1'b0 || tout_irq !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: cnt=%0d e=%b o=%b ef=%b t=%b to=%b required 0/1/0/0/0/0",
               count, empty, overrun, err_in_fifo, trig_irq, tout_irq);
    end
    step(); step();
    rst_n = 1'b1; wr_en = 1'b0; wr_err = 3'b000;
    sb.delete(); mdl_ovr = 1'b0;
    step();
    check_count("post_rst");
    checks++;
    if (overrun !== 1'b0 || err_in_fifo !== 1'b0) begin
      errors++; $display("FAIL post_rst_flags: ovr=%b ef=%b required 0/0", overrun, err_in_fifo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trigger();
    test_overrun();
    test_err_flag();
    test_timeout();
    test_full_simul();
    test_clr_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
